// File: rtl/rect_framebuffer.sv
// -----------------------------------------------------------------------------
// rect_framebuffer
//   Frame store with a rectangle fill engine. The store holds H_RES*V_RES pixels
//   of {r,g,b} (3*CW bits) behind one write port, driven by the engine, and one
//   independent registered read port for scan-out. The read side takes display
//   coordinates and downscales them by SCALE_SHIFT before addressing the store.
//
//   After reset the engine clears the whole store to 0, one word per cycle, and
//   only then reports ready. A FILL command paints a clipped rectangle in
//   row-major order, one pixel per cycle. A CLEAR command paints the whole
//   frame in the supplied colour.
//
// Ports
//   CLOCK_50            sole clock, rising edge
//   reset               synchronous, active-low
//   cmd_valid/cmd_ready command handshake (ready only when idle)
//   cmd_op              0 = CLEAR, 1 = FILL
//   rect_x/rect_y       rectangle top-left, store coordinates (11 bits)
//   rect_w/rect_h       rectangle size in pixels (7 bits)
//   r_in/g_in/b_in      fill colour
//   rd_x/rd_y           display read coordinates (11 bits)
//   r_out/g_out/b_out   read data, registered one cycle after rd_x/rd_y
//   busy                engine is writing (clear or fill)
//   done                one-cycle pulse when a command or the clear completes
// -----------------------------------------------------------------------------
module rect_framebuffer #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int CW          = 8,
    parameter int SCALE_SHIFT = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [10:0]   rect_x,
    input  logic [10:0]   rect_y,
    input  logic [6:0]    rect_w,
    input  logic [6:0]    rect_h,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic [10:0]   rd_x,
    input  logic [10:0]   rd_y,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          busy,
    output logic          done
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // INIT   | clearing the whole store to 0 after reset
    // FILL   | writing one rectangle pixel per cycle
    // DONE   | single cycle, done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int          NPIX = H_RES * V_RES;
    localparam int          AW   = $clog2(NPIX);
    localparam int          DW   = 3 * CW;
    localparam logic [11:0] H12  = 12'(H_RES);
    localparam logic [11:0] V12  = 12'(V_RES);

    // -------------------------------------------------------------------------
    // Engine registers
    // -------------------------------------------------------------------------
    state_t          state_q,    state_d;
    logic [AW-1:0]   wa_q,       wa_d;        // address written this cycle
    logic [AW-1:0]   row_base_q, row_base_d;  // address of first pixel in row
    logic [11:0]     span_q,     span_d;      // clipped width
    logic [11:0]     col_left_q, col_left_d;  // pixels left in row, down-count
    logic [11:0]     row_left_q, row_left_d;  // rows left, down-count
    logic [DW-1:0]   colour_q,   colour_d;

    // -------------------------------------------------------------------------
    // Accept-time geometry and clipping (12-bit, cannot wrap: 2047+127 < 4096)
    // -------------------------------------------------------------------------
    logic [11:0]   acc_x, acc_y, acc_w, acc_h;
    logic [11:0]   x_end, y_end;
    logic          acc_empty;
    logic [AW-1:0] acc_start;

    always_comb begin
        if (cmd_op == 1'b0) begin
            acc_x = 12'd0;
            acc_y = 12'd0;
            acc_w = H12;
            acc_h = V12;
        end else begin
            acc_x = {1'b0, rect_x};
            acc_y = {1'b0, rect_y};
            acc_w = {5'b0, rect_w};
            acc_h = {5'b0, rect_h};
        end

        x_end = acc_x + acc_w;
        if (x_end > H12) begin
            x_end = H12;
        end
        y_end = acc_y + acc_h;
        if (y_end > V12) begin
            y_end = V12;
        end

        // Covers w=0, h=0 and an origin outside the frame: the clipped end
        // never lies past the origin in those cases.
        acc_empty = (x_end <= acc_x) || (y_end <= acc_y);
        acc_start = AW'(24'(acc_y) * 24'(H_RES) + 24'(acc_x));
    end

    // -------------------------------------------------------------------------
    // Next-state logic. INIT and FILL share the same row-major walk; INIT is
    // simply a full-frame walk in colour 0 set up by reset.
    // -------------------------------------------------------------------------
    logic mem_we;

    always_comb begin
        state_d    = state_q;
        wa_d       = wa_q;
        row_base_d = row_base_q;
        span_d     = span_q;
        col_left_d = col_left_q;
        row_left_d = row_left_q;
        colour_d   = colour_q;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    colour_d = {r_in, g_in, b_in};
                    if (acc_empty) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FILL;
                        wa_d       = acc_start;
                        row_base_d = acc_start;
                        span_d     = x_end - acc_x;
                        col_left_d = x_end - acc_x;
                        row_left_d = y_end - acc_y;
                    end
                end
            end
            S_INIT, S_FILL: begin
                mem_we = reset;
                if (col_left_q == 12'd1) begin
                    if (row_left_q == 12'd1) begin
                        state_d = S_DONE;
                    end else begin
                        row_base_d = row_base_q + AW'(H_RES);
                        wa_d       = row_base_q + AW'(H_RES);
                        col_left_d = span_q;
                        row_left_d = row_left_q - 12'd1;
                    end
                end else begin
                    wa_d       = wa_q + AW'(1);
                    col_left_d = col_left_q - 12'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            // Arms the full-frame clear walk; an interrupted fill is abandoned.
            state_q    <= S_INIT;
            wa_q       <= '0;
            row_base_q <= '0;
            span_q     <= H12;
            col_left_q <= H12;
            row_left_q <= V12;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            wa_q       <= wa_d;
            row_base_q <= row_base_d;
            span_q     <= span_d;
            col_left_q <= col_left_d;
            row_left_q <= row_left_d;
            colour_q   <= colour_d;
        end
    end

    // Status outputs are forced during reset so they read as INIT immediately.
    assign busy      = !reset || (state_q == S_INIT) || (state_q == S_FILL);
    assign cmd_ready = reset && (state_q == S_IDLE);
    assign done      = reset && (state_q == S_DONE);

    // -------------------------------------------------------------------------
    // Pixel store: one write port, one registered read port. A same-address
    // read and write in one cycle returns the old word.
    // -------------------------------------------------------------------------
    logic [DW-1:0] mem [NPIX];

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[wa_q] <= colour_q;
        end
    end

    logic [10:0]   rd_sx, rd_sy;
    logic          rd_ok;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] pix_q;

    always_comb begin
        rd_sx   = rd_x >> SCALE_SHIFT;
        rd_sy   = rd_y >> SCALE_SHIFT;
        rd_ok   = ({1'b0, rd_sx} < H12) && ({1'b0, rd_sy} < V12);
        rd_addr = AW'(24'(rd_sy) * 24'(H_RES) + 24'(rd_sx));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pix_q <= '0;
        end else if (rd_ok) begin
            pix_q <= mem[rd_addr];
        end else begin
            pix_q <= '0;
        end
    end

    assign r_out = pix_q[DW-1 -: CW];
    assign g_out = pix_q[2*CW-1 -: CW];
    assign b_out = pix_q[CW-1:0];

endmodule

// File: tb/tb_rect_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_rect_framebuffer
//   Drives rect_framebuffer (reduced frame size so several full clears fit in a
//   short run) with directed and random commands. A plain 2-D array holds the
//   expected frame; fills are applied to it with min() clipping arithmetic and
//   every read and busy/done timing is compared against it.
// -----------------------------------------------------------------------------
module tb_rect_framebuffer;

    localparam int H    = 24;
    localparam int V    = 16;
    localparam int CW   = 8;
    localparam int SH   = 1;
    localparam int NPIX = H * V;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [10:0]   rect_x, rect_y;
    logic [6:0]    rect_w, rect_h;
    logic [CW-1:0] r_in, g_in, b_in;
    logic [10:0]   rd_x, rd_y;
    logic [CW-1:0] r_out, g_out, b_out;
    logic          busy;
    logic          done;

    always #10 CLOCK_50 = ~CLOCK_50;

    rect_framebuffer #(
        .H_RES(H), .V_RES(V), .CW(CW), .SCALE_SHIFT(SH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .rect_x   (rect_x),
        .rect_y   (rect_y),
        .rect_w   (rect_w),
        .rect_h   (rect_h),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out),
        .busy     (busy),
        .done     (done)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] model [V][H];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [23:0] ref_pixel(input int x, input int y);
        int sx;
        int sy;
        sx = x >> SH;
        sy = y >> SH;
        if (sx >= H || sy >= V) return 24'h0;
        return model[sy][sx];
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Paints the expected frame and returns the number of pixels written.
    task automatic model_fill(input bit op, input int x, input int y, input int w,
                              input int h, input logic [23:0] col, output int area);
        int xe;
        int ye;
        if (!op) begin
            x = 0; y = 0; w = H; h = V;
        end
        xe   = imin(x + w, H);
        ye   = imin(y + h, V);
        area = 0;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++) begin
                model[yy][xx] = col;
                area++;
            end
    endtask

    task automatic model_clear;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                model[yy][xx] = 24'h0;
    endtask

    task automatic rd_check(input int x, input int y, input string tag);
        rd_x = 11'(x);
        rd_y = 11'(y);
        tick;
        check(tag, {8'h0, r_out, g_out, b_out}, {8'h0, ref_pixel(x, y)});
    endtask

    task automatic wait_ready;
        int guard;
        guard = 0;
        while (!cmd_ready && guard < NPIX + 50) begin
            tick;
            guard++;
        end
        check("ready_wait", {31'h0, cmd_ready}, 32'd1);
    endtask

    // Offers a command, lets it be accepted, then scrambles the inputs so the
    // engine must be running from its latched copy.
    task automatic start_cmd(input bit op, input int x, input int y, input int w,
                             input int h, input logic [23:0] col);
        wait_ready;
        cmd_op    = op;
        rect_x    = 11'(x);
        rect_y    = 11'(y);
        rect_w    = 7'(w);
        rect_h    = 7'(h);
        {r_in, g_in, b_in} = col;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        rect_x    = 11'($urandom);
        rect_y    = 11'($urandom);
        rect_w    = 7'($urandom);
        rect_h    = 7'($urandom);
        {r_in, g_in, b_in} = 24'($urandom);
    endtask

    // Counts busy cycles from the current sample up to the done pulse.
    task automatic finish_cmd(input int exp_busy, input string tag);
        int n;
        int guard;
        n     = 0;
        guard = 0;
        if (exp_busy == 0) check({tag, "_done_next"}, {31'h0, done}, 32'd1);
        while (!done && guard < NPIX + 50) begin
            if (busy) n++;
            tick;
            guard++;
        end
        check({tag, "_done"}, {31'h0, done}, 32'd1);
        check({tag, "_busy_cycles"}, n, exp_busy);
        tick;
        check({tag, "_one_pulse"}, {30'h0, done, cmd_ready}, 32'd1);
    endtask

    // Runs the post-reset clear with a command held on the inputs throughout.
    task automatic release_and_clear(input string tag);
        int n;
        int guard;
        int ready_seen;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        rect_x    = 11'd0; rect_y = 11'd0; rect_w = 7'd5; rect_h = 7'd5;
        {r_in, g_in, b_in} = 24'hABCDEF;
        reset      = 1'b1;
        n          = 0;
        guard      = 0;
        ready_seen = 0;
        while (!done && guard < NPIX + 50) begin
            if (busy) n++;
            if (cmd_ready) ready_seen++;
            tick;
            guard++;
        end
        cmd_valid = 1'b0;
        check({tag, "_done"}, {31'h0, done}, 32'd1);
        check({tag, "_busy_cycles"}, n, NPIX);
        check({tag, "_no_accept"}, ready_seen, 0);
        tick;
        check({tag, "_idle"}, {30'h0, done, cmd_ready}, 32'd1);
        model_clear();
    endtask

    initial begin
        int area;
        int acc;
        int n;
        int guard;
        logic [23:0] col;
        bit op;
        int x, y, w, h;

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 1'b1;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
        r_in = '0; g_in = '0; b_in = '0;
        rd_x = '0; rd_y = '0;
        model_clear();

        // Reset state
        tick; tick; tick;
        check("rst_busy",  {31'h0, busy}, 32'd1);
        check("rst_ready", {31'h0, cmd_ready}, 32'd0);
        check("rst_done",  {31'h0, done}, 32'd0);
        check("rst_pix",   {8'h0, r_out, g_out, b_out}, 32'd0);
        release_and_clear("init");
        for (int i = 0; i < 8; i++)
            rd_check($urandom_range(0, 2 * H - 1), $urandom_range(0, 2 * V - 1), "init_read");

        // Directed fill and its neighbourhood
        col = 24'h000064;
        start_cmd(1'b1, 10, 5, 4, 3, col);
        model_fill(1'b1, 10, 5, 4, 3, col, area);
        finish_cmd(area, "fill_12");
        rd_check(20, 10, "fill_in_tl");
        rd_check(27, 15, "fill_in_br");
        rd_check(28, 10, "fill_right_out");
        rd_check(20, 16, "fill_below_out");

        // Clipped corner fill, must not wrap into row 0 / column 0
        col = 24'h11AA22;
        start_cmd(1'b1, H - 2, V - 2, 5, 5, col);
        model_fill(1'b1, H - 2, V - 2, 5, 5, col, area);
        finish_cmd(area, "clip");
        rd_check(2 * H - 1, 2 * V - 1, "clip_corner");
        rd_check(0, 2 * V - 2, "clip_no_wrap_col");
        rd_check(2 * H - 2, 0, "clip_no_wrap_row");
        rd_check(0, 0, "clip_origin");

        // Empty rectangles
        start_cmd(1'b1, 3, 3, 0, 4, 24'hFFFFFF);
        finish_cmd(0, "empty_w");
        start_cmd(1'b1, H, 0, 4, 4, 24'hFFFFFF);
        finish_cmd(0, "empty_x");
        rd_check(6, 6, "empty_unchanged");

        // cmd_valid held for the whole command gives one accept
        wait_ready;
        cmd_op = 1'b1; rect_x = 11'd2; rect_y = 11'd2; rect_w = 7'd3; rect_h = 7'd2;
        {r_in, g_in, b_in} = 24'h303030;
        cmd_valid = 1'b1;
        acc = 0; n = 0; guard = 0;
        while (guard < 200) begin
            if (cmd_valid && cmd_ready) acc++;
            if (busy) n++;
            if (done) break;
            tick;
            guard++;
        end
        cmd_valid = 1'b0;
        check("hold_done", {31'h0, done}, 32'd1);
        check("hold_accepts", acc, 1);
        check("hold_busy", n, 6);
        model_fill(1'b1, 2, 2, 3, 2, 24'h303030, area);
        tick;
        rd_check(4, 4, "hold_pix");

        // Out-of-range display coordinates
        rd_check(2 * H, 0, "oob_x");
        rd_check(0, 2 * V, "oob_y");
        rd_check(2047, 2047, "oob_max");

        // Same-cycle read and write of one address returns the old word
        start_cmd(1'b1, 3, 2, 1, 1, 24'h0000AA);
        model_fill(1'b1, 3, 2, 1, 1, 24'h0000AA, area);
        finish_cmd(area, "rw_prep");
        start_cmd(1'b1, 3, 2, 2, 1, 24'h00BB00);
        rd_x = 11'd6;
        rd_y = 11'd4;
        tick;
        check("rw_old_data", {8'h0, r_out, g_out, b_out}, 32'h0000AA);
        finish_cmd(1, "rw_fill");
        model_fill(1'b1, 3, 2, 2, 1, 24'h00BB00, area);
        rd_check(6, 4, "rw_new_data");

        // Random commands
        for (int it = 0; it < 40; it++) begin
            op  = ($urandom_range(0, 15) != 0);
            x   = $urandom_range(0, H + 4);
            y   = $urandom_range(0, V + 4);
            w   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
            h   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
            col = op ? 24'($urandom) : 24'h0;
            start_cmd(op, x, y, w, h, col);
            model_fill(op, x, y, w, h, col, area);
            finish_cmd(area, "rand_cmd");
            for (int k = 0; k < 6; k++)
                rd_check($urandom_range(0, 2 * H + 6), $urandom_range(0, 2 * V + 6), "rand_read");
        end

        // Reset during the 5th FILL cycle
        start_cmd(1'b1, 0, 0, 10, 4, 24'h5A5A5A);
        rd_x = 11'd0;
        rd_y = 11'd0;
        tick; tick; tick; tick;
        reset = 1'b0;
        #1;
        check("midrst_busy",  {31'h0, busy}, 32'd1);
        check("midrst_ready", {31'h0, cmd_ready}, 32'd0);
        check("midrst_done",  {31'h0, done}, 32'd0);
        tick;
        check("midrst_pix", {8'h0, r_out, g_out, b_out}, 32'd0);
        check("midrst_state_busy", {31'h0, busy}, 32'd1);
        release_and_clear("reinit");
        rd_check(0, 0, "reinit_fill_gone");
        rd_check(20, 10, "reinit_old_gone");
        for (int i = 0; i < 8; i++)
            rd_check($urandom_range(0, 2 * H - 1), $urandom_range(0, 2 * V - 1), "reinit_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rect_framebuffer.md
RECT_FRAMEBUFFER -- requirements
Module: rect_framebuffer

Interface
REQ-001 SHALL have parameter H_RES, default 320, meaning stored frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 240, meaning stored frame height in pixels.
REQ-003 SHALL have parameter CW, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameter SCALE_SHIFT, default 1, meaning display-to-store coordinate right shift (1 = 2x upscale).
REQ-005 SHALL have port CLOCK_50, input, 1 bit, the sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: engine idle and able to accept.
REQ-009 SHALL have port cmd_op, input, 1 bit: 0 = CLEAR (whole frame), 1 = FILL (rectangle).
REQ-010 SHALL have ports rect_x and rect_y, inputs, 11 bits each: rectangle top-left in store coordinates.
REQ-011 SHALL have ports rect_w and rect_h, inputs, 7 bits each: rectangle size in pixels.
REQ-012 SHALL have ports r_in, g_in and b_in, inputs, CW bits each: fill colour.
REQ-013 SHALL have ports rd_x and rd_y, inputs, 11 bits each: display read coordinates.
REQ-014 SHALL have ports r_out, g_out and b_out, outputs, CW bits each: pixel read data.
REQ-015 SHALL have port busy, output, 1 bit: engine writing.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-017 SHALL store H_RES*V_RES words of 3*CW bits in one write port and one independent read port.
REQ-018 SHALL implement FSM states IDLE, INIT, FILL and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a command on a cycle with cmd_valid=1 and cmd_ready=1, latching op, geometry and colour; later input changes SHALL NOT affect the running command.
REQ-020 SHALL treat CLEAR as FILL with x=0, y=0, w=H_RES, h=V_RES.
REQ-021 SHALL clip at accept time: x_end = min(x+w, H_RES), y_end = min(y+h, V_RES), computed at 12-bit width with no wrap.
REQ-022 SHALL, in FILL, write exactly one pixel per cycle in row-major order starting on the cycle after accept.
REQ-023 SHALL go to DONE when the last clipped pixel is written, assert done for that one DONE cycle, and return to IDLE on the next cycle.
REQ-024 SHALL treat an empty rectangle (w=0, h=0, x>=H_RES or y>=V_RES) as accept -> DONE on the next cycle, with no writes.
REQ-025 SHALL hold busy=1 in INIT and FILL and 0 otherwise.
REQ-026 SHALL compute the read address as (rd_y>>SCALE_SHIFT)*H_RES + (rd_x>>SCALE_SHIFT).
REQ-027 SHALL register r_out/g_out/b_out one cycle after rd_x/rd_y are presented.
REQ-028 SHALL return 0 on all channels when the shifted coordinate is >= H_RES or >= V_RES.
REQ-029 SHALL, when a read and a write hit the same address in the same cycle, return the old data.
REQ-030 SHALL keep the read port operating during INIT and FILL.

Reset
REQ-031 SHALL, on a cycle with reset=0, set state=INIT, cmd_ready=0, busy=1, done=0 and r_out=g_out=b_out=0.
REQ-032 SHALL, after reset is released, clear all H_RES*V_RES words to 0 in INIT at one word per cycle, then pass through DONE (done pulse) to IDLE.
REQ-033 SHALL, when reset is asserted mid-FILL, abandon the command immediately; partially written pixels are overwritten by the INIT clear.
REQ-034 SHALL NOT accept commands presented during reset or INIT; they are dropped.

Verification
REQ-035 Reset, then release -> busy=1 for exactly 76800 cycles, one done pulse, then cmd_ready=1; every read returns 0.
REQ-036 FILL x=10, y=20, w=4, h=3, colour (0,0,100) -> 12 busy cycles, done pulse; rd (20,40) returns (0,0,100) one cycle later; rd (28,40) returns 0.
REQ-037 FILL x=318, y=238, w=5, h=5 -> only 4 pixels written (clipped), done after 4 FILL cycles, no wrap into row 0 or column 0.
REQ-038 FILL w=0 -> done on the cycle after accept, memory unchanged; cmd_valid held high while busy -> exactly one accept.
REQ-039 Reset asserted on the 5th FILL cycle -> state INIT, outputs 0, then a full 76800-cycle clear; old pixels read as 0.
REQ-040 rd_x=640 or rd_y=480 -> outputs 0; read of an address written in the same cycle -> pre-write value.
